// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vga_pkg
//  Purpose : Shared VGA geometry, framebuffer sizing and pixel type for the
//            timing generator, framebuffer arbiter and bit generator.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE   = 640;   // visible pixels per line
  localparam int V_ACTIVE   = 480;   // visible lines per frame
  localparam int FB_W       = 160;   // framebuffer width (4x4 screen pixels per FB pixel)
  localparam int FB_H       = 120;   // framebuffer height
  localparam int ADDR_W     = 15;    // framebuffer word address width
  localparam int DATA_W     = 8;     // pixel width, RRRGGGBB
  localparam int COORD_W    = 10;    // width of the screen h/v counters
  localparam int FB_COORD_W = COORD_W - 2;  // screen coordinate divided by 4
  localparam int FB_WORDS   = FB_W * FB_H;  // 19200 words

  typedef logic [DATA_W-1:0] rgb_t;  // RRRGGGBB

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_fb_addr.sv
`default_nettype none
// ============================================================================
//  Module  : vga_fb_addr
//  Purpose : Combinational mapping of a framebuffer (x, y) coordinate to its
//            RAM word address: y*160 + x, built from shifts and adds.
//  Ports   : fb_x_i    in  FB_COORD_W  framebuffer column (h_count >> 2)
//            fb_y_i    in  FB_COORD_W  framebuffer row    (v_count >> 2)
//            fb_addr_o out ADDR_W      word address, wraps modulo 2^ADDR_W
//  Rev     : 1.0  initial release
// ============================================================================
module vga_fb_addr
  import vga_pkg::*;
(
  input  logic [FB_COORD_W-1:0] fb_x_i,
  input  logic [FB_COORD_W-1:0] fb_y_i,
  output logic [ADDR_W-1:0]     fb_addr_o
);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] x_ext;

  // 160 = 128 + 32, so y*160 = (y<<7) + (y<<5).
  always_comb begin
    y_ext     = ADDR_W'(fb_y_i);
    x_ext     = ADDR_W'(fb_x_i);
    fb_addr_o = (y_ext << 7) + (y_ext << 5) + x_ext;
  end

endmodule : vga_fb_addr
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : vga_fb_arbiter
//  Purpose : Shares one single-port synchronous framebuffer RAM between VGA
//            scan-out (one read per active pixel slot) and a game-logic
//            writer (granted in every other free memory cycle). Delays the
//            syncs by one pixel to line up with the fetch latency.
//  Ports   : clk_i         in  1       100 MHz system clock
//            rst_ni        in  1       asynchronous active-low reset
//            pix_en_i      in  1       25 MHz pixel strobe (1 clk in 4)
//            h_count_i     in  10      current pixel, sampled on pix_en_i
//            v_count_i     in  10      current line, sampled on pix_en_i
//            h_sync_in_i   in  1       horizontal sync in (active-low)
//            v_sync_in_i   in  1       vertical sync in (active-low)
//            wr_req_i      in  1       writer request, held until wr_ack_o
//            wr_addr_i     in  ADDR_W  writer word address
//            wr_data_i     in  DATA_W  writer pixel value
//            wr_ack_o      out 1       write accepted (same cycle as mem_we_o)
//            mem_addr_o    out ADDR_W  RAM address (registered)
//            mem_we_o      out 1       RAM write enable (registered)
//            mem_wdata_o   out DATA_W  RAM write data (registered)
//            mem_rdata_i   in  DATA_W  RAM read data, 1 clk after address
//            rgb_o         out DATA_W  pixel colour to DAC
//            h_sync_o      out 1       h_sync_in_i delayed one pixel
//            v_sync_o      out 1       v_sync_in_i delayed one pixel
//  Rev     : 1.0  initial release
// ============================================================================
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_en_i,
  input  logic [COORD_W-1:0] h_count_i,
  input  logic [COORD_W-1:0] v_count_i,
  input  logic               h_sync_in_i,
  input  logic               v_sync_in_i,
  input  logic               wr_req_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic               wr_ack_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_we_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output rgb_t               rgb_o,
  output logic               h_sync_o,
  output logic               v_sync_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        phase_q,       phase_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic              mem_we_q,      mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic              wr_ack_q,      wr_ack_d;
  logic              rd_pend_q,     rd_pend_d;     // read address on the RAM port
  logic              rd_cap_q,      rd_cap_d;      // read data on mem_rdata_i
  rgb_t              pix_buf_q,     pix_buf_d;
  logic              slot_act_q,    slot_act_d;    // previous pixel slot was visible
  rgb_t              rgb_q,         rgb_d;
  logic              hs_dly_q,      hs_dly_d;
  logic              vs_dly_q,      vs_dly_d;
  logic              h_sync_q,      h_sync_d;
  logic              v_sync_q,      v_sync_d;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              active;
  logic              rd_slot;
  logic              grant;
  logic              wr_in_range;
  logic [ADDR_W-1:0] fb_addr;

  vga_fb_addr u_fb_addr (
    .fb_x_i    (h_count_i[COORD_W-1:2]),
    .fb_y_i    (v_count_i[COORD_W-1:2]),
    .fb_addr_o (fb_addr)
  );

  always_comb begin
    active      = (h_count_i < COORD_W'(H_ACTIVE)) && (v_count_i < COORD_W'(V_ACTIVE));
    rd_slot     = pix_en_i & active;
    // While wr_ack_q is high the writer has not yet seen the ack, so its
    // still-asserted request is the one just served.
    grant       = wr_req_i & ~wr_ack_q & ~rd_slot;
    wr_in_range = wr_addr_i < ADDR_W'(FB_WORDS);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // A strobe at any phase realigns the counter.
    phase_d     = pix_en_i ? 2'd0 : phase_q + 2'd1;

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;

    if (rd_slot) begin
      mem_addr_d = fb_addr;
    end else if (grant) begin
      mem_addr_d  = wr_addr_i;
      mem_wdata_d = wr_data_i;
      // Out-of-range writes are acknowledged but never reach the RAM.
      mem_we_d    = wr_in_range;
      wr_ack_d    = 1'b1;
    end

    rd_pend_d  = rd_slot;
    rd_cap_d   = rd_pend_q;
    pix_buf_d  = rd_cap_q ? mem_rdata_i : pix_buf_q;

    slot_act_d = slot_act_q;
    rgb_d      = rgb_q;
    hs_dly_d   = hs_dly_q;
    vs_dly_d   = vs_dly_q;
    h_sync_d   = h_sync_q;
    v_sync_d   = v_sync_q;
    if (pix_en_i) begin
      rgb_d      = slot_act_q ? pix_buf_q : '0;
      slot_act_d = active;
      hs_dly_d   = h_sync_in_i;
      vs_dly_d   = v_sync_in_i;
      h_sync_d   = hs_dly_q;
      v_sync_d   = vs_dly_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q     <= 2'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_cap_q    <= 1'b0;
      pix_buf_q   <= '0;
      slot_act_q  <= 1'b0;
      rgb_q       <= '0;
      hs_dly_q    <= 1'b1;
      vs_dly_q    <= 1'b1;
      h_sync_q    <= 1'b1;
      v_sync_q    <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rd_pend_q   <= rd_pend_d;
      rd_cap_q    <= rd_cap_d;
      pix_buf_q   <= pix_buf_d;
      slot_act_q  <= slot_act_d;
      rgb_q       <= rgb_d;
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      h_sync_q    <= h_sync_d;
      v_sync_q    <= v_sync_d;
    end
  end

  assign wr_ack_o    = wr_ack_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rgb_o       = rgb_q;
  assign h_sync_o    = h_sync_q;
  assign v_sync_o    = v_sync_q;

endmodule : vga_fb_arbiter
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vga_fb_arbiter
//  Purpose : Directed self-checking bench for vga_fb_arbiter with a
//            behavioural single-port synchronous framebuffer RAM.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_en;
  logic [9:0]        h_count, v_count;
  logic              hs_in, vs_in;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  rgb_t              rgb;
  logic              h_sync, v_sync;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int wc_snap;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pix_en_i    (pix_en),
    .h_count_i   (h_count),
    .v_count_i   (v_count),
    .h_sync_in_i (hs_in),
    .v_sync_in_i (vs_in),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ack_o    (wr_ack),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .rgb_o       (rgb),
    .h_sync_o    (h_sync),
    .v_sync_o    (v_sync)
  );

  // Framebuffer RAM: 2-state storage so unwritten words read as 0.
  bit [DATA_W-1:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we && mem_addr < 15'(FB_WORDS)) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 4-clk pixel slot with the strobe in the first cycle.
  task automatic slot(input int h, input int v, input logic hs, input logic vs);
    h_count = 10'(h);
    v_count = 10'(v);
    hs_in   = hs;
    vs_in   = vs;
    pix_en  = 1'b1;
    step();
    pix_en  = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    pix_en  = 1'b0;
    h_count = 10'd0;
    v_count = 10'd500;
    hs_in   = 1'b1;
    vs_in   = 1'b1;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // ---------------- reset state
    repeat (2) step();
    chk("rst_rgb",   32'(rgb),       32'h0);
    chk("rst_ack",   32'(wr_ack),    32'h0);
    chk("rst_we",    32'(mem_we),    32'h0);
    chk("rst_addr",  32'(mem_addr),  32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_hs",    32'(h_sync),    32'h1);
    chk("rst_vs",    32'(v_sync),    32'h1);
    rst_n = 1'b1;
    step();

    // ---------------- blanking write
    wr_req = 1'b1; wr_addr = 15'h0123; wr_data = 8'hE0;
    step();
    chk("blk_ack",   32'(wr_ack),    32'h1);
    chk("blk_we",    32'(mem_we),    32'h1);
    chk("blk_addr",  32'(mem_addr),  32'h0123);
    chk("blk_wdata", 32'(mem_wdata), 32'hE0);
    wr_req = 1'b0;
    step();
    chk("blk_ack_end", 32'(wr_ack), 32'h0);
    chk("blk_we_end",  32'(mem_we), 32'h0);

    // preload word 161 through the writer port
    wr_req = 1'b1; wr_addr = 15'd161; wr_data = 8'h1C;
    step();
    chk("pre_ack", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    step();

    // ---------------- collision: read wins, write next cycle
    h_count = 10'd8; v_count = 10'd4; pix_en = 1'b1;
    wr_req = 1'b1; wr_addr = 15'h0200; wr_data = 8'h55;
    step();
    chk("col_rd_addr", 32'(mem_addr), 32'd162);
    chk("col_rd_we",   32'(mem_we),   32'h0);
    chk("col_rd_ack",  32'(wr_ack),   32'h0);
    pix_en = 1'b0;
    step();
    chk("col_wr_ack",   32'(wr_ack),    32'h1);
    chk("col_wr_we",    32'(mem_we),    32'h1);
    chk("col_wr_addr",  32'(mem_addr),  32'h0200);
    chk("col_wr_wdata", 32'(mem_wdata), 32'h55);
    wr_req = 1'b0;
    step();
    chk("col_ack_end", 32'(wr_ack), 32'h0);

    // ---------------- out-of-range and last valid word
    wc_snap = wr_count;
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'hAA;
    step();
    chk("oor_ack", 32'(wr_ack), 32'h1);
    chk("oor_we",  32'(mem_we), 32'h0);
    wr_req = 1'b0;
    step();
    chk("oor_ram_untouched", 32'(wr_count), 32'(wc_snap));
    wr_req = 1'b1; wr_addr = 15'd19199; wr_data = 8'h77;
    step();
    chk("last_ack", 32'(wr_ack), 32'h1);
    chk("last_we",  32'(mem_we), 32'h1);
    wr_req = 1'b0;
    step();

    // ---------------- scan mapping and sync delay
    slot(4,   4,  1'b1, 1'b1);
    chk("scan_a_rgb", 32'(rgb), 32'h00);      // word 162, never written
    slot(640, 4,  1'b0, 1'b1);
    chk("scan_b_rgb", 32'(rgb), 32'h1C);      // word 161
    chk("scan_b_hs",  32'(h_sync), 32'h1);
    slot(524, 4,  1'b1, 1'b0);
    chk("scan_c_rgb", 32'(rgb), 32'h00);      // previous slot h=640
    chk("scan_c_hs",  32'(h_sync), 32'h0);
    chk("scan_c_vs",  32'(v_sync), 32'h1);
    slot(640, 4,  1'b1, 1'b1);
    chk("scan_d_rgb", 32'(rgb), 32'hE0);      // word 0x123 = 1*160+131
    chk("scan_d_vs",  32'(v_sync), 32'h0);
    slot(128, 12, 1'b1, 1'b1);
    slot(640, 12, 1'b1, 1'b1);
    chk("scan_f_rgb", 32'(rgb), 32'h55);      // word 512 = 3*160+32
    slot(128, 480, 1'b0, 1'b0);
    chk("scan_g_rgb", 32'(rgb), 32'h00);
    slot(639, 479, 1'b0, 1'b0);
    chk("scan_h_rgb", 32'(rgb), 32'h00);      // previous slot v=480
    slot(640, 0,   1'b0, 1'b0);
    chk("scan_i_rgb", 32'(rgb), 32'h77);      // word 19199
    chk("scan_i_hs",  32'(h_sync), 32'h0);
    chk("scan_i_vs",  32'(v_sync), 32'h0);

    // ---------------- asynchronous reset mid-request
    wr_req = 1'b1; wr_addr = 15'h0050; wr_data = 8'h33;
    step();
    chk("ar_pre_ack", 32'(wr_ack), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rgb",   32'(rgb),       32'h0);
    chk("ar_ack",   32'(wr_ack),    32'h0);
    chk("ar_we",    32'(mem_we),    32'h0);
    chk("ar_addr",  32'(mem_addr),  32'h0);
    chk("ar_wdata", 32'(mem_wdata), 32'h0);
    chk("ar_hs",    32'(h_sync),    32'h1);
    chk("ar_vs",    32'(v_sync),    32'h1);
    repeat (3) step();
    chk("ar_hold_ack", 32'(wr_ack), 32'h0);
    rst_n = 1'b1;
    step();
    chk("ar_rereq_ack",  32'(wr_ack),   32'h1);
    chk("ar_rereq_we",   32'(mem_we),   32'h1);
    chk("ar_rereq_addr", 32'(mem_addr), 32'h0050);
    wr_req = 1'b0;
    step();

    // ---------------- strobe at phase 2 resynchronises and still reads
    h_count = 10'd0; v_count = 10'd0; pix_en = 1'b1;
    step();
    chk("rs_first_addr", 32'(mem_addr), 32'h0);
    pix_en = 1'b0;
    step();
    h_count = 10'd4; v_count = 10'd8; pix_en = 1'b1;
    wr_req = 1'b1; wr_addr = 15'h0060; wr_data = 8'h44;
    step();
    chk("rs_rd_addr", 32'(mem_addr), 32'd321);
    chk("rs_rd_we",   32'(mem_we),   32'h0);
    chk("rs_rd_ack",  32'(wr_ack),   32'h0);
    pix_en = 1'b0;
    step();
    chk("rs_wr_ack",  32'(wr_ack),   32'h1);
    chk("rs_wr_addr", 32'(mem_addr), 32'h0060);
    wr_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vga_fb_arbiter
`default_nettype wire
